// File: rtl/crg_capture_buffer.sv
// crg_capture_buffer: multi-channel capture memory with stop-when-full or ring modes and a one-cycle read port
module crg_capture_buffer #(
  parameter int DATA_W = 256,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     ring_mode_i,
  input  logic [AW:0]              max_words_i,
  input  logic                     dvld_i,
  input  logic [NUM_CH*DATA_W-1:0] din_i,
  input  logic                     rd_req_i,
  input  logic [AW-1:0]            rd_addr_i,
  input  logic [CW-1:0]            rd_ch_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_vld_o,
  output logic                     rd_err_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AW:0]              count_o,
  output logic [AW-1:0]            wr_ptr_o,
  output logic                     wrapped_o,
  output logic                     drop_o
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW:0] NCH  = (CW+1)'(NUM_CH);
  state_t             state;
  logic               ring_q;
  logic [AW:0]        len_q;
  logic               we;
  logic               rd_bad;
  logic [DATA_W-1:0]  mem [DEPTH][NUM_CH];
  assign we     = (state == CAPTURE) && dvld_i && !arm_i;
  assign rd_bad = (state == CAPTURE) || ({1'b0, rd_ch_i} >= NCH);
  assign busy_o = (state == CAPTURE);
  assign done_o = (state == DONE);
  // Capture FSM: arm restarts everything, writes advance the pointer, length or stop ends capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ring_q    <= 1'b0;
      len_q     <= '0;
      count_o   <= '0;
      wr_ptr_o  <= '0;
      wrapped_o <= 1'b0;
      drop_o    <= 1'b0;
    end else if (arm_i) begin
      state     <= CAPTURE;
      ring_q    <= ring_mode_i;
      len_q     <= (max_words_i == '0 || max_words_i > FULL) ? FULL : max_words_i;
      count_o   <= '0;
      wr_ptr_o  <= '0;
      wrapped_o <= 1'b0;
      drop_o    <= 1'b0;
    end else if (state == CAPTURE) begin
      if (we) begin
        wr_ptr_o <= wr_ptr_o + 1'b1;
        count_o  <= (count_o == FULL) ? FULL : count_o + 1'b1;
        if (ring_q && count_o == FULL) wrapped_o <= 1'b1;
      end
      if (stop_i || (we && !ring_q && count_o + 1'b1 == len_q)) state <= DONE;
    end else if (dvld_i) begin
      drop_o <= 1'b1;
    end
  end
  // Capture memory: all channels written together, never reset
  always_ff @(posedge clk_i) begin
    if (we) for (int c = 0; c < NUM_CH; c++) mem[wr_ptr_o][c] <= din_i[c*DATA_W +: DATA_W];
  end
  // Read port: one-cycle latency, rejected requests leave data untouched
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= '0;
      rd_vld_o  <= 1'b0;
      rd_err_o  <= 1'b0;
    end else begin
      rd_vld_o <= rd_req_i && !rd_bad;
      rd_err_o <= rd_req_i && rd_bad;
      if (rd_req_i && !rd_bad) rd_data_o <= mem[rd_addr_i][rd_ch_i];
    end
  end
endmodule

// File: tb/tb_crg_capture_buffer.sv
// tb_crg_capture_buffer: directed scoreboard bench for crg_capture_buffer
module tb_crg_capture_buffer;
  localparam int DW = 16, NC = 3, DP = 8, AW = 3, CW = 2;
  logic           clk = 0, rst_n = 0;
  logic           arm = 0, stop = 0, ring = 0, dvld = 0, rd_req = 0;
  logic [AW:0]    max_words = '0;
  logic [NC*DW-1:0] din = '0;
  logic [AW-1:0]  rd_addr = '0;
  logic [CW-1:0]  rd_ch = '0;
  logic [DW-1:0]  rd_data;
  logic           rd_vld, rd_err, busy, done, wrapped, drop;
  logic [AW:0]    count;
  logic [AW-1:0]  wr_ptr;
  int checks = 0, errors = 0;
  typedef struct { logic err; logic [DW-1:0] data; string tag; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] last_rd = '0;

  crg_capture_buffer #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm), .stop_i(stop), .ring_mode_i(ring),
    .max_words_i(max_words), .dvld_i(dvld), .din_i(din), .rd_req_i(rd_req),
    .rd_addr_i(rd_addr), .rd_ch_i(rd_ch), .rd_data_o(rd_data), .rd_vld_o(rd_vld),
    .rd_err_o(rd_err), .busy_o(busy), .done_o(done), .count_o(count),
    .wr_ptr_o(wr_ptr), .wrapped_o(wrapped), .drop_o(drop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [NC*DW-1:0] word(input int k);
    return {DW'(32'h200 + k), DW'(32'h100 + k), DW'(k)};
  endfunction

  task automatic rd(input string tag, input int addr, input int ch, input logic err, input logic [DW-1:0] data);
    exp_t e;
    e.err = err; e.data = err ? last_rd : data; e.tag = tag;
    if (!err) last_rd = data;
    sb.push_back(e);
    rd_req = 1; rd_addr = AW'(addr); rd_ch = CW'(ch);
    cyc();
    rd_req = 0;
    e = sb.pop_front();
    chk({e.tag, "_vld"}, {31'b0, rd_vld}, {31'b0, !e.err});
    chk({e.tag, "_err"}, {31'b0, rd_err}, {31'b0, e.err});
    chk({e.tag, "_data"}, {16'b0, rd_data}, {16'b0, e.data});
  endtask

  task automatic do_arm(input logic r, input int mw);
    arm = 1; ring = r; max_words = (AW+1)'(mw);
    cyc();
    arm = 0;
  endtask

  initial begin
    #2;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_count", {28'b0, count}, 0);
    chk("rst_wrptr", {29'b0, wr_ptr}, 0);
    chk("rst_flags", {28'b0, wrapped, drop, rd_vld, rd_err}, 0);
    chk("rst_rddata", {16'b0, rd_data}, 0);
    cyc(); rst_n = 1; cyc();
    // stop mode, length 5, seven words
    do_arm(0, 5);
    chk("stop_busy", {31'b0, busy}, 1);
    dvld = 1;
    for (int k = 1; k <= 7; k++) begin
      din = word(k);
      cyc();
      if (k == 4) chk("stop_notdone4", {31'b0, done}, 0);
      if (k == 5) begin
        chk("stop_done5", {31'b0, done}, 1);
        chk("stop_count5", {28'b0, count}, 5);
        chk("stop_drop5", {31'b0, drop}, 0);
      end
    end
    dvld = 0;
    chk("stop_count", {28'b0, count}, 5);
    chk("stop_wrptr", {29'b0, wr_ptr}, 5);
    chk("stop_drop", {31'b0, drop}, 1);
    for (int a = 0; a < 5; a++) rd($sformatf("stop_e%0d", a), a, 0, 0, DW'(a + 1));
    rd("rd_ch2_a1", 1, 2, 0, 16'h0202);
    rd("rd_ch3_err", 1, 3, 1, 16'h0);
    rd("rd_ch1_a4", 4, 1, 0, 16'h0105);
    stop = 1; cyc(); stop = 0;
    chk("done_ign_stop", {31'b0, done}, 1);
    // arm, stop and dvld together in DONE
    arm = 1; stop = 1; dvld = 1; din = word(8'h99); max_words = 0; ring = 0;
    cyc();
    arm = 0; stop = 0; dvld = 0;
    chk("combo_busy", {31'b0, busy}, 1);
    chk("combo_count", {28'b0, count}, 0);
    chk("combo_drop", {31'b0, drop}, 0);
    chk("combo_wrptr", {29'b0, wr_ptr}, 0);
    stop = 1; cyc(); stop = 0;
    chk("combo_done", {31'b0, done}, 1);
    rd("combo_e0", 0, 0, 0, 16'h0001);
    // ring mode, eleven words, read rejected during capture
    do_arm(1, 3);
    dvld = 1;
    for (int k = 1; k <= 11; k++) begin
      din = word(k);
      cyc();
      if (k == 8) chk("ring_wrap8", {31'b0, wrapped}, 0);
      if (k == 9) chk("ring_wrap9", {31'b0, wrapped}, 1);
    end
    dvld = 0;
    chk("ring_busy", {31'b0, busy}, 1);
    stop = 1;
    rd("ring_rd_cap", 0, 0, 1, 16'h0);
    stop = 0;
    chk("ring_done", {31'b0, done}, 1);
    chk("ring_count", {28'b0, count}, 8);
    chk("ring_wrptr", {29'b0, wr_ptr}, 3);
    chk("ring_wrapped", {31'b0, wrapped}, 1);
    rd("ring_e0", 0, 0, 0, 16'h0009);
    rd("ring_e3", 3, 0, 0, 16'h0004);
    rd("ring_e7c2", 7, 2, 0, 16'h0208);
    // asynchronous reset mid-capture
    do_arm(0, 0);
    dvld = 1;
    for (int k = 1; k <= 3; k++) begin din = word(8'h20 + k); cyc(); end
    dvld = 0;
    chk("pre_rst_count", {28'b0, count}, 3);
    #2 rst_n = 0; #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_count", {28'b0, count}, 0);
    chk("arst_wrptr", {29'b0, wr_ptr}, 0);
    chk("arst_flags", {28'b0, wrapped, drop, rd_vld, rd_err}, 0);
    chk("arst_rddata", {16'b0, rd_data}, 0);
    last_rd = '0;
    cyc(); rst_n = 1; cyc();
    // rearm with length beyond DEPTH: behaves as DEPTH
    do_arm(0, 15);
    dvld = 1;
    for (int k = 1; k <= 8; k++) begin
      din = word(8'h30 + k);
      cyc();
      if (k == 7) chk("big_notdone7", {31'b0, done}, 0);
    end
    dvld = 0;
    chk("big_done", {31'b0, done}, 1);
    chk("big_count", {28'b0, count}, 8);
    chk("big_drop", {31'b0, drop}, 0);
    rd("big_e0", 0, 0, 0, 16'h0031);
    rd("big_e7c1", 7, 1, 0, 16'h0138);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crg_capture_buffer.md
CRG_CAPTURE_BUFFER -- requirements
Module: crg_capture_buffer

Interface
REQ-001 SHALL have parameter DATA_W, 256, width of one channel word.
REQ-002 SHALL have parameter NUM_CH, 3, number of captured channels (a, b, c of CRG).
REQ-003 SHALL have parameter DEPTH, 256, entries per channel; power of two, at least 4; AW = $clog2(DEPTH).
REQ-004 SHALL have port clk_i  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port arm_i  in  1  pulse: start a new capture.
REQ-007 SHALL have port stop_i  in  1  pulse: end capture.
REQ-008 SHALL have port ring_mode_i  in  1  0 = stop-when-full, 1 = circular overwrite; sampled at arm.
REQ-009 SHALL have port max_words_i  in  AW+1  capture length in stop mode; sampled at arm; 0 or >DEPTH means DEPTH.
REQ-010 SHALL have port dvld_i  in  1  a capture word is valid this cycle.
REQ-011 SHALL have port din_i  in  NUM_CH*DATA_W  channel words, channel 0 in LSBs.
REQ-012 SHALL have port rd_req_i  in  1  read request.
REQ-013 SHALL have port rd_addr_i  in  AW  entry index to read.
REQ-014 SHALL have port rd_ch_i  in  $clog2(NUM_CH) (min 1)  channel to read.
REQ-015 SHALL have port rd_data_o  out  DATA_W  read data.
REQ-016 SHALL have port rd_vld_o  out  1  rd_data_o valid.
REQ-017 SHALL have port rd_err_o  out  1  one-cycle pulse: request rejected.
REQ-018 SHALL have port busy_o  out  1  high in CAPTURE.
REQ-019 SHALL have port done_o  out  1  high in DONE.
REQ-020 SHALL have port count_o  out  AW+1  entries held, saturating at DEPTH.
REQ-021 SHALL have port wr_ptr_o  out  AW  next write index; oldest entry when wrapped_o is high.
REQ-022 SHALL have port wrapped_o  out  1  sticky: ring mode overwrote data since arm.
REQ-023 SHALL have port drop_o  out  1  sticky: dvld_i seen outside CAPTURE since arm or reset.

Function
REQ-024 SHALL implement states IDLE, CAPTURE, DONE; reset state IDLE.
REQ-025 SHALL on arm_i in any state enter CAPTURE next cycle, clear wr_ptr, count, wrapped and drop, and latch ring_mode_i and max_words_i.
REQ-026 SHALL give arm_i priority over stop_i and dvld_i in the same cycle; a dvld_i word in the arm cycle is not written and does not set drop.
REQ-027 SHALL in CAPTURE with dvld_i write all NUM_CH words of din_i at wr_ptr, increment wr_ptr modulo DEPTH, and increment count saturating at DEPTH.
REQ-028 SHALL in stop mode enter DONE on the cycle after the write that makes count equal the latched length; no further writes occur.
REQ-029 SHALL in ring mode ignore the length, wrap wr_ptr from DEPTH-1 to 0, and set wrapped_o on the first write made while count equals DEPTH.
REQ-030 SHALL on stop_i in CAPTURE enter DONE next cycle; a dvld_i word in the stop cycle is still written.
REQ-031 SHALL ignore stop_i in IDLE and DONE.
REQ-032 SHALL set drop_o when dvld_i is high in IDLE or DONE, excluding arm cycles.
REQ-033 SHALL accept reads only in IDLE or DONE: rd_data_o = entry rd_addr_i of channel rd_ch_i, with rd_vld_o high exactly one cycle after rd_req_i.
REQ-034 SHALL reject rd_req_i in CAPTURE, or with rd_ch_i >= NUM_CH, by pulsing rd_err_o one cycle later with rd_vld_o low and rd_data_o unchanged.
REQ-035 SHALL return stored data for any rd_addr_i in accepted reads, regardless of count; unwritten entries are undefined.
REQ-036 SHALL keep busy_o and done_o as direct decodes of the registered state.

Reset
REQ-037 SHALL when rst_n_i is low asynchronously force IDLE, and clear rd_data_o, rd_vld_o, rd_err_o, count_o, wr_ptr_o, wrapped_o and drop_o to 0.
REQ-038 SHALL not reset memory contents; reset mid-capture abandons the capture.

Verification
REQ-039 SHALL cover stop mode: arm with max_words=5, 7 dvld words 1..7 -> entries 0..4 = 1..5, count 5, done_o, drop_o set by words 6 and 7.
REQ-040 SHALL cover ring mode DEPTH=8: 11 words 1..11, then stop -> count 8, wr_ptr 3, wrapped 1, entry 0 = 9, entry 3 = 4.
REQ-041 SHALL cover reads: after DONE, rd_req for channel 2, addr 1 -> rd_vld next cycle with channel-2 word 2; rd_ch=3 -> rd_err pulse, no rd_vld.
REQ-042 SHALL cover rd_req during CAPTURE -> rd_err pulse, stored data unchanged.
REQ-043 SHALL cover arm, stop and dvld asserted together in DONE -> CAPTURE, count 0, nothing written, drop_o 0.
REQ-044 SHALL cover rst_n_i low after 3 captured words -> all outputs 0 and IDLE immediately; rearm captures from entry 0.
